// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle CPU datapath: two-byte fetch, then a
// memory, ALU or branch step, with a memory-ready timeout, opcode trapping and HALT resume.
module multicycle_control_fsm #(
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            opcode,
   input  logic [DATA_WIDTH-1:0] aluout,
   input  logic                  memReady,
   input  logic                  run,
   output logic                  memReq,
   output logic                  pcSelect,
   output logic                  pcEnable,
   output logic                  adrSelect,
   output logic                  memEnable,
   output logic                  ir1En,
   output logic                  ir2En,
   output logic                  regSelect,
   output logic                  wd3Select,
   output logic                  regWrite,
   output logic                  op1Sel,
   output logic                  op2Sel,
   output logic                  aluOutEn,
   output logic [2:0]            aluControl,
   output logic                  halted,
   output logic                  illegalOp,
   output logic                  busTimeout,
   output logic [2:0]            state_o
);

   typedef enum logic [2:0] {
      FETCH1 = 3'd0,
      FETCH2 = 3'd1,
      MEM    = 3'd2,
      ALU    = 3'd3,
      BRANCH = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam int                CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit                TMO_EN   = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0]  TMO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             r_illegal;
   logic             r_timeout;
   logic             w_set_ill;
   logic             w_set_tmo;
   logic             w_mem_wait;
   logic             w_zero;

   function automatic logic [2:0] alu_ctl(input logic [1:0] op);
      case (op)
         2'b00:   alu_ctl = 3'b010;
         2'b01:   alu_ctl = 3'b110;
         2'b10:   alu_ctl = 3'b000;
         default: alu_ctl = 3'b001;
      endcase
   endfunction

   assign w_zero     = (aluout == '0);
   assign state_o    = r_state;
   assign illegalOp  = r_illegal;
   assign busTimeout = r_timeout;

   always_comb begin
      memReq     = 1'b0;
      pcSelect   = 1'b0;
      pcEnable   = 1'b0;
      adrSelect  = 1'b0;
      memEnable  = 1'b0;
      ir1En      = 1'b0;
      ir2En      = 1'b0;
      regSelect  = 1'b0;
      wd3Select  = 1'b0;
      regWrite   = 1'b0;
      op1Sel     = 1'b1;
      op2Sel     = 1'b0;
      aluOutEn   = 1'b0;
      aluControl = 3'b010;
      halted     = 1'b0;
      w_next     = r_state;
      w_set_ill  = 1'b0;
      w_set_tmo  = 1'b0;
      w_mem_wait = 1'b0;
      case (r_state)
         FETCH1: begin
            memReq     = 1'b1;
            op1Sel     = 1'b0;
            op2Sel     = 1'b1;
            ir1En      = memReady;
            pcEnable   = memReady;
            w_mem_wait = 1'b1;
            if (memReady) w_next = FETCH2;
         end
         FETCH2: begin
            memReq     = 1'b1;
            op1Sel     = 1'b0;
            op2Sel     = 1'b1;
            ir2En      = memReady;
            pcEnable   = memReady;
            w_mem_wait = 1'b1;
            if (memReady) begin
               casez (opcode)
                  4'b000?:                   w_next = MEM;
                  4'b01??:                   w_next = ALU;
                  4'b1000, 4'b1001, 4'b1010: w_next = BRANCH;
                  4'b1011:                   w_next = HALT;
                  default: begin
                     w_next    = HALT;
                     w_set_ill = 1'b1;
                  end
               endcase
            end
         end
         MEM: begin
            memReq     = 1'b1;
            adrSelect  = 1'b1;
            memEnable  = (opcode == 4'b0001);
            regWrite   = (opcode == 4'b0000) && memReady;
            w_mem_wait = 1'b1;
            if (memReady) w_next = FETCH1;
         end
         ALU: begin
            regSelect  = 1'b1;
            wd3Select  = 1'b1;
            regWrite   = 1'b1;
            aluOutEn   = 1'b1;
            aluControl = alu_ctl(opcode[1:0]);
            w_next     = FETCH1;
         end
         BRANCH: begin
            pcEnable = 1'b1;
            pcSelect = (opcode == 4'b1000) ||
                       ((opcode == 4'b1001) && w_zero) ||
                       ((opcode == 4'b1010) && !w_zero);
            w_next   = FETCH1;
         end
         HALT: begin
            halted = 1'b1;
            if (run) w_next = FETCH1;
         end
         default: w_next = FETCH1;
      endcase
      // A ready in the last allowed cycle wins over the timeout
      if (TMO_EN && w_mem_wait && !memReady && (r_cnt == TMO_LAST)) begin
         w_next    = HALT;
         w_set_tmo = 1'b1;
      end
   end

   assign w_cnt_next = (w_mem_wait && !memReady && (w_next == r_state)) ?
                       r_cnt + CNT_W'(1) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= FETCH1;
         r_cnt     <= '0;
         r_illegal <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (r_state == HALT && run) begin
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
         end else begin
            if (w_set_ill) r_illegal <= 1'b1;
            if (w_set_tmo) r_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: fetch/execute sequences, memory
// waits, branches, illegal-opcode halt, bus timeout and reset mid-access.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] opcode;
   logic [7:0] aluout;
   logic       memReady;
   logic       run;
   logic       memReq, pcSelect, pcEnable, adrSelect, memEnable, ir1En, ir2En;
   logic       regSelect, wd3Select, regWrite, op1Sel, op2Sel, aluOutEn;
   logic [2:0] aluControl;
   logic       halted, illegalOp, busTimeout;
   logic [2:0] state_o;

   int passed = 0;
   int total  = 0;

   multicycle_control_fsm #(.DATA_WIDTH(8), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .aluout(aluout),
      .memReady(memReady), .run(run),
      .memReq(memReq), .pcSelect(pcSelect), .pcEnable(pcEnable),
      .adrSelect(adrSelect), .memEnable(memEnable), .ir1En(ir1En),
      .ir2En(ir2En), .regSelect(regSelect), .wd3Select(wd3Select),
      .regWrite(regWrite), .op1Sel(op1Sel), .op2Sel(op2Sel),
      .aluOutEn(aluOutEn), .aluControl(aluControl), .halted(halted),
      .illegalOp(illegalOp), .busTimeout(busTimeout), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // FETCH1 -> FETCH2 -> execute state with memory always ready
   task automatic fetch(input logic [3:0] op);
      opcode   = op;
      memReady = 1'b1;
      step();
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; opcode = 4'b0000; aluout = 8'h00; memReady = 1'b0; run = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
      chk("reset_state", state_o, 0);
      chk("reset_memReq", memReq, 1);
      chk("reset_op2Sel", op2Sel, 1);
      chk("reset_op1Sel", op1Sel, 0);
      chk("reset_aluCtl", aluControl, 3'b010);
      chk("reset_ir1En", ir1En, 0);
      chk("reset_pcEnable", pcEnable, 0);
      chk("reset_regWrite", regWrite, 0);
      chk("reset_halted", halted, 0);
      chk("reset_illegal", illegalOp, 0);
      chk("reset_busTmo", busTimeout, 0);

      // ADD: states 0,1,3,0
      opcode = 4'b0100; memReady = 1'b1;
      #1;
      chk("add_f1_ir1En", ir1En, 1);
      chk("add_f1_pcEn", pcEnable, 1);
      step();
      chk("add_f2_state", state_o, 1);
      chk("add_f2_ir2En", ir2En, 1);
      chk("add_f2_ir1En", ir1En, 0);
      step();
      chk("add_alu_state", state_o, 3);
      chk("add_alu_regWrite", regWrite, 1);
      chk("add_alu_aluOutEn", aluOutEn, 1);
      chk("add_alu_aluCtl", aluControl, 3'b010);
      chk("add_alu_regSelect", regSelect, 1);
      step();
      chk("add_back_f1", state_o, 0);

      // SUB
      fetch(4'b0101);
      chk("sub_state", state_o, 3);
      chk("sub_aluCtl", aluControl, 3'b110);
      step();
      // OR
      fetch(4'b0111);
      chk("or_aluCtl", aluControl, 3'b001);
      step();

      // STORE with three wait cycles in MEM
      fetch(4'b0001);
      memReady = 1'b0;
      #1;
      chk("st_state", state_o, 2);
      chk("st_adrSelect", adrSelect, 1);
      for (int i = 0; i < 3; i++) begin
         chk("st_wait_memEnable", memEnable, 1);
         chk("st_wait_regWrite", regWrite, 0);
         step();
         chk("st_wait_state", state_o, 2);
      end
      memReady = 1'b1;
      #1;
      chk("st_last_memEnable", memEnable, 1);
      chk("st_last_regWrite", regWrite, 0);
      step();
      chk("st_back_f1", state_o, 0);

      // LOAD writes the register only on ready
      fetch(4'b0000);
      chk("ld_state", state_o, 2);
      chk("ld_regWrite", regWrite, 1);
      chk("ld_memEnable", memEnable, 0);
      step();

      // Branches
      aluout = 8'h00;
      fetch(4'b1001);
      chk("beqz0_state", state_o, 4);
      chk("beqz0_pcSelect", pcSelect, 1);
      chk("beqz0_pcEnable", pcEnable, 1);
      step();
      aluout = 8'h01;
      fetch(4'b1001);
      chk("beqz1_pcSelect", pcSelect, 0);
      chk("beqz1_pcEnable", pcEnable, 1);
      step();
      fetch(4'b1010);
      chk("bnez1_pcSelect", pcSelect, 1);
      chk("bnez1_pcEnable", pcEnable, 1);
      step();
      aluout = 8'h00;
      fetch(4'b1000);
      chk("jmp_pcSelect", pcSelect, 1);
      chk("jmp_pcEnable", pcEnable, 1);
      step();
      chk("jmp_back_f1", state_o, 0);

      // Illegal opcode traps to HALT until run
      fetch(4'b1100);
      chk("ill_state", state_o, 5);
      chk("ill_halted", halted, 1);
      chk("ill_flag", illegalOp, 1);
      chk("ill_memReq", memReq, 0);
      for (int i = 0; i < 5; i++) step();
      chk("ill_still_halt", state_o, 5);
      chk("ill_still_flag", illegalOp, 1);
      run = 1'b1;
      step();
      run = 1'b0;
      memReady = 1'b0;
      #1;
      chk("ill_resume_state", state_o, 0);
      chk("ill_resume_flag", illegalOp, 0);
      chk("ill_resume_halted", halted, 0);

      // Bus timeout after 16 wait cycles in FETCH1
      for (int i = 0; i < 15; i++) begin
         chk("tmo_wait_ir1En", ir1En, 0);
         step();
      end
      chk("tmo_c16_state", state_o, 0);
      chk("tmo_c16_ir1En", ir1En, 0);
      step();
      chk("tmo_state", state_o, 5);
      chk("tmo_flag", busTimeout, 1);
      chk("tmo_illegal", illegalOp, 0);
      run = 1'b1;
      step();
      run = 1'b0;
      #1;
      chk("tmo_resume_flag", busTimeout, 0);
      chk("tmo_resume_state", state_o, 0);

      // Ready on the 16th wait cycle beats the timeout
      opcode = 4'b0100;
      for (int i = 0; i < 15; i++) step();
      memReady = 1'b1;
      #1;
      chk("notmo_ir1En", ir1En, 1);
      step();
      chk("notmo_state", state_o, 1);
      chk("notmo_flag", busTimeout, 0);
      step();
      step();

      // Reset during a MEM wait
      fetch(4'b0001);
      memReady = 1'b0;
      step();
      step();
      chk("rstmem_pre_state", state_o, 2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("rstmem_state", state_o, 0);
      chk("rstmem_busTmo", busTimeout, 0);
      chk("rstmem_memEnable", memEnable, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Parametrised next-generation main control FSM for the multicycle CPU datapath. It sequences a two-byte instruction fetch, then a memory, ALU or branch step, and drives all datapath enables. Compared with the previous controller it adds:
- a memory ready/wait handshake with a configurable timeout;
- a DATA_WIDTH-generic zero test;
- four ALU ops, plus BNEZ;
- illegal-opcode trapping;
- HALT resume via a run input.

Parameters:
DATA_WIDTH, 8, width of aluout used for the zero test (min 1)
TIMEOUT, 16, max consecutive cycles waiting for memReady before bus-error halt; 0 disables the timeout

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous active-high reset
opcode  input  4  instruction opcode, stable from FETCH2 until return to FETCH1
aluout  input  DATA_WIDTH  ALU result, for the branch zero test
memReady  input  1  memory completes the current access this cycle
run  input  1  resume request, honoured only in HALT
memReq  output  1  memory access active
pcSelect, pcEnable, adrSelect, memEnable, ir1En, ir2En  output  1 each  datapath controls
regSelect, wd3Select, regWrite, op1Sel, op2Sel, aluOutEn  output  1 each  datapath controls
aluControl  output  3  ALU op: 010 add, 110 sub, 000 and, 001 or
halted  output  1  FSM in HALT
illegalOp  output  1  sticky: halted on an illegal opcode
busTimeout  output  1  sticky: halted on a memory timeout
state_o  output  3  current state encoding, for debug

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- State encoding: FETCH1=0, FETCH2=1, MEM=2, ALU=3, BRANCH=4, HALT=5. Codes 6 and 7 go to FETCH1.
- Reset: the next state is FETCH1; the wait counter, illegalOp and busTimeout clear. Reset overrides everything, including a reset mid-access.
- All control outputs are a combinational decode of the state, opcode, memReady and aluout.
  - After reset (FETCH1, memReady=0): memReq=1, op2Sel=1, aluControl=010; all other outputs 0.
- Opcode map:
  - Memory group: 0000 LOAD, 0001 STORE.
  - ALU group: 0100 ADD, 0101 SUB, 0110 AND, 0111 OR.
  - Branch group: 1000 JMP, 1001 BEQZ, 1010 BNEZ, 1011 HALT.
  - Illegal: 0010, 0011 and 11xx.
- FETCH1: memReq=1, ir1En=memReady, pcEnable=memReady, op1Sel=0, op2Sel=1. Advance to FETCH2 only when memReady=1.
- FETCH2: same as FETCH1 but ir2En replaces ir1En. When memReady=1:
  - 00xx (legal) goes to MEM;
  - 01xx goes to ALU;
  - 1000–1010 go to BRANCH;
  - 1011 goes to HALT;
  - illegal goes to HALT with illegalOp set.
- MEM: memReq=1, adrSelect=1, op1Sel=1, op2Sel=0.
  - STORE: memEnable=1 for the whole state.
  - LOAD: regWrite=memReady.
  - Exits to FETCH1 when memReady=1.
- ALU: single cycle. regSelect=1, wd3Select=1, regWrite=1, aluOutEn=1, aluControl from the opcode, then FETCH1.
- BRANCH: single cycle. pcEnable=1, then FETCH1. pcSelect=1 when:
  - JMP;
  - BEQZ and aluout==0;
  - BNEZ and aluout!=0.
- Outside ALU, aluControl=010. Outside FETCH1/FETCH2, op1Sel=1 and op2Sel=0.
- HALT: all enables 0; halted=1. run=1 goes to FETCH1 next cycle and clears both sticky flags. run outside HALT is ignored.
- Wait counter (width clog2(TIMEOUT+1)):
  - counts +1 each cycle in FETCH1, FETCH2 or MEM while memReady=0;
  - clears on any state change or when memReady=1.
  - TIMEOUT>0 and the count reaches TIMEOUT-1 with memReady still 0: next state HALT, busTimeout set, no enable pulsed.
  - memReady=1 in that same cycle wins: normal advance.
  - With TIMEOUT=1, the first cycle with memReady=0 halts.
- Outputs never depend on a stale opcode: the opcode is only sampled in FETCH2 and later.

Test Plan:
- Reset, then memReady held 1, opcode 0100 → states 0,1,3,0. In the ALU cycle: regWrite=1, aluOutEn=1, aluControl=010. With opcode 0101: aluControl=110.
- Opcode 0001, memReady low 3 cycles in MEM then high → memEnable=1 for all 4 MEM cycles, regWrite stays 0, returns to FETCH1.
- BEQZ with aluout=0 → pcSelect=1. BEQZ with aluout=8'h01 → pcSelect=0. BNEZ with 8'h01 → pcSelect=1. JMP → pcSelect=1. pcEnable=1 in each BRANCH cycle.
- Opcode 1100 → HALT with halted=1 and illegalOp=1. Hold run=0 for 5 cycles: stays halted. run=1 → FETCH1, illegalOp=0.
- TIMEOUT=16, memReady=0 in FETCH1 → HALT entered after the 16th wait cycle, busTimeout=1, ir1En never 1. Repeat with memReady=1 on cycle 16: no timeout.
- Assert reset during a MEM wait → state_o=0 next cycle, busTimeout=0, memEnable=0.
